// File: rtl/bf16_acc_sched.sv
// Round-robin two-requester front end for the BF16 accelerator: accepts one op at a time,
// sequences the accelerator through ISSUE/WAIT and returns the result with sticky FP flags.
module bf16_acc_sched #(
  parameter int          MIN_LAT = 1,
  parameter int          TIMEOUT = 16,
  parameter logic [3:0]  MAX_OP  = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [31:0] req0_c,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [31:0] req1_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_fpcsr,
  output logic        rsp_err,
  output logic        acc_enable,
  output logic [3:0]  acc_operation,
  output logic [31:0] acc_operand_a,
  output logic [15:0] acc_operand_b,
  output logic [31:0] acc_operand_c,
  input  logic [31:0] acc_result,
  input  logic [3:0]  acc_fpcsr,
  input  logic        acc_valid,
  output logic [3:0]  fflags_sticky,
  input  logic        fflags_clr,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MINL = CW'(MIN_LAT - 1);
  localparam logic [CW-1:0] TMO  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          id_q, id_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [31:0]   c_q, c_d;
  logic [31:0]   res_q, res_d;
  logic [3:0]    fp_q, fp_d;
  logic          err_q, err_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [3:0]    sticky_q, sticky_d;

  logic gnt0, gnt1, rsp_hs;
  logic [3:0] sel_op;

  // rr_q names the requester that wins a tie
  assign gnt1   = req1_valid & (~req0_valid | rr_q);
  assign gnt0   = req0_valid & ~gnt1;
  assign sel_op = gnt1 ? req1_op : req0_op;
  assign rsp_hs = (state_q == RESP) & rsp_ready;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    id_d          = id_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    res_d         = res_q;
    fp_d          = fp_q;
    err_d         = err_q;
    wcnt_d        = wcnt_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_valid     = 1'b0;
    acc_enable    = 1'b0;
    acc_operation = 4'h0;
    acc_operand_a = 32'h0;
    acc_operand_b = 16'h0;
    acc_operand_c = 32'h0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          id_d = gnt1;
          rr_d = ~gnt1;
          op_d = sel_op;
          a_d  = gnt1 ? req1_a : req0_a;
          b_d  = gnt1 ? req1_b : req0_b;
          c_d  = gnt1 ? req1_c : req0_c;
          if (sel_op > MAX_OP) begin
            res_d   = 32'h0;
            fp_d    = 4'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE, WAIT: begin
        acc_enable    = 1'b1;
        acc_operation = op_q;
        acc_operand_a = a_q;
        acc_operand_b = b_q;
        acc_operand_c = c_q;
        if (state_q == ISSUE) begin
          wcnt_d  = '0;
          state_d = WAIT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          // a capture in the timeout cycle still wins
          if (acc_valid && (wcnt_q >= MINL)) begin
            res_d   = acc_result;
            fp_d    = acc_fpcsr;
            err_d   = 1'b0;
            state_d = RESP;
          end else if (wcnt_q == TMO) begin
            res_d   = 32'h0;
            fp_d    = 4'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // new flags from a completing response survive a simultaneous clear
  assign sticky_d = (fflags_clr ? 4'h0 : sticky_q) | ((rsp_hs && !err_q) ? fp_q : 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= 4'h0;
      a_q      <= 32'h0;
      b_q      <= 16'h0;
      c_q      <= 32'h0;
      res_q    <= 32'h0;
      fp_q     <= 4'h0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      sticky_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      res_q    <= res_d;
      fp_q     <= fp_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp_id        = id_q;
  assign rsp_result    = res_q;
  assign rsp_fpcsr     = fp_q;
  assign rsp_err       = err_q;
  assign fflags_sticky = sticky_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bf16_acc_sched.sv
// Bench for bf16_acc_sched: accelerator stub with programmable latency plus a
// transaction-level model predicting grants, response timing, contents and sticky flags.
module tb_bf16_acc_sched;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_c, req1_a, req1_c;
  logic [15:0] req0_b, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_fpcsr;
  logic        acc_enable, acc_valid;
  logic [3:0]  acc_operation, acc_fpcsr;
  logic [31:0] acc_operand_a, acc_operand_c, acc_result;
  logic [15:0] acc_operand_b;
  logic [3:0]  fflags_sticky;
  logic        fflags_clr, busy;

  bf16_acc_sched #(.MIN_LAT(1), .TIMEOUT(TIMEOUT), .MAX_OP(4'hA)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_fpcsr(rsp_fpcsr), .rsp_err(rsp_err),
    .acc_enable(acc_enable), .acc_operation(acc_operation),
    .acc_operand_a(acc_operand_a), .acc_operand_b(acc_operand_b), .acc_operand_c(acc_operand_c),
    .acc_result(acc_result), .acc_fpcsr(acc_fpcsr), .acc_valid(acc_valid),
    .fflags_sticky(fflags_sticky), .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // stub knobs
  bit          fix_en = 0;
  logic [31:0] fix_res = 0;
  logic [3:0]  fix_fp = 0;
  int          stub_lat = 1, lat_next = 1, en_cnt = 0;
  bit          rnd_lat = 0;

  function automatic logic [31:0] stub_res(logic [3:0] op, logic [31:0] a, logic [15:0] b, logic [31:0] c);
    return fix_en ? fix_res : ((a ^ {b, b}) + c + {28'd0, op});
  endfunction
  function automatic logic [3:0] stub_fp(logic [3:0] op, logic [31:0] a);
    return fix_en ? fix_fp : (a[3:0] ^ op);
  endfunction

  // accelerator: result valid once enable has been seen for stub_lat+1 cycles, junk otherwise
  always @(negedge clk) begin
    if (acc_enable) en_cnt = en_cnt + 1; else en_cnt = 0;
    acc_valid  = acc_enable && (en_cnt >= stub_lat + 1);
    acc_result = acc_valid ? stub_res(acc_operation, acc_operand_a, acc_operand_b, acc_operand_c) : 32'hDEAD_BEEF;
    acc_fpcsr  = acc_valid ? stub_fp(acc_operation, acc_operand_a) : 4'hF;
  end

  // pending requests per requester
  bit          pend [2];
  logic [3:0]  p_op [2];
  logic [31:0] p_a  [2];
  logic [15:0] p_b  [2];
  logic [31:0] p_c  [2];
  bit rdy = 1, clr = 0;

  // model of the outstanding transaction
  bit          m_out = 0, m_legal = 0, m_rr = 0, m_err = 0, m_id = 0;
  int          m_t = 0, m_rsp_cyc = 0, n_rsp = 0, en_seen = 0;
  logic [3:0]  m_op = 0, m_fp = 0, m_sticky = 0;
  logic [31:0] m_a = 0, m_c = 0, m_res = 0;
  logic [15:0] m_b = 0;
  bit          last_erv = 0;
  logic [31:0] last_res = 0;
  logic        last_err = 0;
  int          obs_gr[$];

  task automatic new_req(int k, bit allow_illegal);
    pend[k] = 1;
    if (allow_illegal && ($urandom % 100 < 15)) p_op[k] = 4'($urandom_range(11, 15));
    else p_op[k] = 4'($urandom_range(0, 10));
    p_a[k] = $urandom; p_b[k] = 16'($urandom); p_c[k] = $urandom;
  endtask

  task automatic accept(int k);
    int lat;
    m_out = 1; m_id = k[0]; m_t = cyc; m_rr = ~k[0]; pend[k] = 0;
    m_op = p_op[k]; m_a = p_a[k]; m_b = p_b[k]; m_c = p_c[k];
    m_legal = (p_op[k] <= 4'hA);
    lat = rnd_lat ? $urandom_range(1, 20) : lat_next;
    stub_lat = lat;
    if (!m_legal) begin
      m_res = 0; m_fp = 0; m_err = 1; m_rsp_cyc = cyc + 1;
    end else if (lat <= TIMEOUT) begin
      m_res = stub_res(m_op, m_a, m_b, m_c); m_fp = stub_fp(m_op, m_a); m_err = 0;
      m_rsp_cyc = cyc + 2 + lat;
    end else begin
      m_res = 0; m_fp = 0; m_err = 1; m_rsp_cyc = cyc + 2 + TIMEOUT;
    end
  endtask

  task automatic cyc_step();
    bit e0, e1, erv, een;
    logic [3:0] s;
    @(negedge clk);
    req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_c = p_c[0];
    req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_c = p_c[1];
    rsp_ready = rdy; fflags_clr = clr;
    #1;
    e0  = !m_out && pend[0] && (!pend[1] || !m_rr);
    e1  = !m_out && pend[1] && (!pend[0] || m_rr);
    erv = m_out && (cyc >= m_rsp_cyc);
    een = m_out && m_legal && (cyc > m_t) && (cyc < m_rsp_cyc);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, m_out);
    chk("rsp_valid", rsp_valid, erv);
    chk("acc_enable", acc_enable, een);
    chk("acc_operation", acc_operation, een ? m_op : 4'h0);
    chk("acc_operand_a", acc_operand_a, een ? m_a : 32'h0);
    chk("acc_operand_b", acc_operand_b, een ? m_b : 16'h0);
    chk("acc_operand_c", acc_operand_c, een ? m_c : 32'h0);
    if (erv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_fpcsr", rsp_fpcsr, m_fp);
      chk("rsp_err", rsp_err, m_err);
    end
    chk("fflags_sticky", fflags_sticky, m_sticky);
    if (acc_enable) en_seen++;
    if (req0_ready) obs_gr.push_back(0);
    if (req1_ready) obs_gr.push_back(1);
    if (rsp_valid && rsp_ready) begin last_res = rsp_result; last_err = rsp_err; end
    last_erv = erv;
    s = clr ? 4'h0 : m_sticky;
    if (erv && rdy) begin
      if (!m_err) s = s | m_fp;
      m_out = 0; n_rsp++;
    end
    m_sticky = s;
    if (e0 || e1) accept(e1 ? 1 : 0);
  endtask

  task automatic run_until(int target, int budget, string tag);
    int i = 0;
    while (n_rsp < target && i < budget) begin cyc_step(); i++; end
    if (n_rsp < target) chk({tag, "_timeout"}, n_rsp, target);
  endtask

  task automatic model_reset();
    m_out = 0; m_rr = 0; m_sticky = 0; pend[0] = 0; pend[1] = 0;
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    int base;
    logic [3:0] sv;
    rst_n = 0; rsp_ready = 1; fflags_clr = 0;
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req0_c = 0; req1_a = 0; req1_b = 0; req1_c = 0;
    model_reset();
    #12;
    chk("rst_acc_enable", acc_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sticky", fflags_sticky, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk); rst_n = 1;

    // single op from requester 0, prompt accelerator
    fix_en = 1; fix_res = 32'h4040_0000; fix_fp = 4'b0001; lat_next = 1;
    pend[0] = 1; p_op[0] = 4'h4; p_a[0] = 32'h3F80_0000; p_b[0] = 16'h4000; p_c[0] = 0;
    run_until(1, 30, "t1");
    cyc_step();
    chk("t1_result", last_res, 32'h4040_0000);
    chk("t1_err", last_err, 0);
    chk("t1_sticky", fflags_sticky, 4'b0001);
    fix_en = 0;

    // both requesters valid every cycle: alternating grants
    @(negedge clk); #1 rst_n = 0; model_reset();
    @(negedge clk); #1 rst_n = 1;
    obs_gr.delete(); base = n_rsp;
    for (int i = 0; i < 60 && obs_gr.size() < 4; i++) begin
      if (!pend[0]) new_req(0, 0);
      if (!pend[1]) new_req(1, 0);
      cyc_step();
    end
    pend[0] = 0; pend[1] = 0;
    run_until(base + 4, 30, "t2");
    chk("t2_ngrants", obs_gr.size(), 4);
    for (int i = 0; i < 4 && i < obs_gr.size(); i++) chk($sformatf("t2_grant%0d", i), obs_gr[i], i % 2);

    // illegal op on requester 1
    cyc_step();
    sv = m_sticky; en_seen = 0; base = n_rsp;
    new_req(1, 0); p_op[1] = 4'hC;
    run_until(base + 1, 10, "t3");
    cyc_step();
    chk("t3_en_pulses", en_seen, 0);
    chk("t3_err", last_err, 1);
    chk("t3_result", last_res, 0);
    chk("t3_sticky", fflags_sticky, sv);

    // accelerator never answers: timeout
    en_seen = 0; base = n_rsp; lat_next = 1000;
    new_req(0, 0);
    run_until(base + 1, 40, "t4");
    chk("t4_en_cycles", en_seen, TIMEOUT + 1);
    chk("t4_err", last_err, 1);
    chk("t4_result", last_res, 0);

    // response back-pressure, then clear coinciding with new flags
    fix_en = 1; fix_fp = 4'b0100; fix_res = $urandom; lat_next = 2; rdy = 0; base = n_rsp;
    new_req(0, 0);
    for (int i = 0; i < 20 && !last_erv; i++) cyc_step();
    new_req(1, 0);
    for (int i = 0; i < 4; i++) cyc_step();
    chk("t5_held_busy", busy, 1);
    rdy = 1; clr = 1;
    cyc_step();
    clr = 0;
    cyc_step();
    chk("t5_sticky", fflags_sticky, 4'b0100);
    run_until(base + 2, 30, "t5");
    fix_en = 0;

    // reset in the middle of WAIT
    lat_next = 10; new_req(0, 0);
    for (int i = 0; i < 20 && !(m_out && cyc >= m_t + 5); i++) cyc_step();
    chk("t6_in_wait", acc_enable, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_acc_enable", acc_enable, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_sticky", fflags_sticky, 0);
    chk("t6_busy", busy, 0);
    model_reset(); base = n_rsp;
    @(negedge clk); #1 rst_n = 1;
    for (int i = 0; i < 30; i++) cyc_step();
    chk("t6_no_rsp", n_rsp, base);

    // random traffic
    rnd_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) if (!pend[k] && ($urandom % 100 < 40)) new_req(k, 1);
      rdy = ($urandom % 100) < 70;
      clr = ($urandom % 100) < 5;
      cyc_step();
    end
    rdy = 1; clr = 0;
    for (int i = 0; i < 200 && (m_out || pend[0] || pend[1]); i++) cyc_step();
    chk("drain_idle", m_out || pend[0] || pend[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bf16_acc_sched.md
Name: bf16_acc_sched

Overview:
- Two-requester scheduler and sequencer in front of the BF16 accelerator (conversion, min/max and add/mul/FMA units).
- Accepts operation requests on valid/ready ports and arbitrates between them round-robin.
- Drives the accelerator's enable/operation/operand bus for exactly one operation at a time.
- Captures the registered result and returns it on a valid/ready response port tagged with the requester id, plus a sticky FP-flag register.

Parameters:
- MIN_LAT, 1: minimum WAIT cycles before acc_valid is trusted (≥1).
- TIMEOUT, 16: WAIT cycles after which an operation is aborted with an error (> MIN_LAT).
- MAX_OP, 4'hA: highest legal operation code; codes above it are rejected.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 request valid
- req0_ready  out  1  requester 0 accepted (handshake = valid & ready)
- req0_op  in  4  operation code
- req0_a / req0_b / req0_c  in  32/16/32  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_c  same as requester 0
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester index
- rsp_result  out  32  result
- rsp_fpcsr  out  4  per-op flags
- rsp_err  out  1  illegal op or timeout
- acc_enable  out  1  accelerator enable
- acc_operation  out  4  to accelerator
- acc_operand_a / acc_operand_b / acc_operand_c  out  32/16/32  to accelerator
- acc_result  in  32  from accelerator (registered)
- acc_fpcsr  in  4  from accelerator
- acc_valid  in  1  from accelerator
- fflags_sticky  out  4  OR of fpcsr over all completed responses
- fflags_clr  in  1  clear the sticky flags
- busy  out  1  FSM state ≠ IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, rr pointer=0, all outputs 0, operand/result holding regs 0, fflags_sticky=0. Reset mid-operation drops acc_enable immediately and discards the operation; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqX_ready = reqX_valid & granted; at most one ready per cycle; ready only in IDLE.
  - Grant: if only one requester is valid, grant it. If both are valid, grant the rr pointer's requester.
  - On handshake: latch op/a/b/c and id, set rr pointer to the other requester.
  - If op > MAX_OP: rsp_err=1, result=0, fpcsr=0, go to RESP without touching the accelerator.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): acc_enable=1, acc_* driven from the latched regs. wait_cnt←0, go to WAIT.
- WAIT:
  - acc_enable stays 1; acc_* are held stable; wait_cnt increments each cycle.
  - Capture when acc_valid & (wait_cnt ≥ MIN_LAT−1): latch acc_result and acc_fpcsr, rsp_err=0, go to RESP.
  - Otherwise, if wait_cnt == TIMEOUT−1: result=0, fpcsr=0, rsp_err=1, go to RESP.
  - Capture takes priority over timeout when both occur in the same cycle.
- RESP:
  - acc_enable=0, acc_operation=0; rsp_valid=1 with all rsp_* held stable until rsp_ready.
  - On handshake go to IDLE. No new request is accepted in the handshake cycle; the earliest acceptance is the next cycle.
- Outputs outside ISSUE/WAIT: acc_enable=0, acc_operation=0, acc_operands=0.
- Latency: accept in cycle T, ISSUE in T+1, WAIT from T+2; with MIN_LAT=1 and a prompt acc_valid, rsp_valid is asserted in T+3. Illegal op: rsp_valid in T+1.
- Sticky flags: sticky ← (fflags_clr ? 0 : sticky) | (rsp handshake & !rsp_err ? rsp_fpcsr : 0). When clear and update coincide, the new flags survive.
- rsp_id width is fixed at 1; rr pointer toggles only on a granted handshake, never on a stall.

Test Plan:
1. Single op, requester 0: op=4'h4, a=32'h3F80_0000, b=16'h4000; stub asserts acc_valid next cycle with result 32'h4040_0000, fpcsr 4'b0001. Expect rsp_valid at T+3, id=0, result 32'h4040_0000, err=0, fflags_sticky=4'b0001.
2. Both requesters valid every cycle for 4 ops (rsp_ready=1). Expect grant order 0,1,0,1 and exactly one ready per acceptance.
3. Illegal op 4'hC on requester 1. Expect no acc_enable pulse, rsp_valid at T+1, err=1, result=0, sticky unchanged.
4. Stub never asserts acc_valid, TIMEOUT=16. Expect acc_enable high for 17 cycles (ISSUE + 16 WAIT), then rsp_err=1, result=0.
5. Hold rsp_ready=0 for 5 cycles. Expect rsp_* stable, both req_ready=0, busy=1; accept resumes the cycle after the handshake. In the same cycle, fflags_clr with a new fpcsr 4'b0100 gives sticky=4'b0100.
6. Drop rst_n during WAIT. Expect acc_enable=0 and rsp_valid=0 asynchronously, sticky=0, no response emitted after release.
